pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter RA_W, default 5: register-address width.
REQ-002 Parameter NUM_SRC, default 2: number of source operands checked per decoded instruction.
REQ-003 Parameter MUL_CYC, default 4, legal range 2..16: EX occupancy in cycles of a multi-cycle op.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_id_valid  in  1  ID stage holds a valid instruction.
REQ-007 i_id_src  in  NUM_SRC*RA_W  source register addresses; source k in bits [k*RA_W +: RA_W].
REQ-008 i_id_src_used  in  NUM_SRC  per-source read flag.
REQ-009 i_id_dst  in  RA_W  destination register.
REQ-010 i_id_regwr  in  1  instruction writes i_id_dst.
REQ-011 i_id_load  in  1  instruction is a load (data valid at end of MEM).
REQ-012 i_id_multi  in  1  instruction is multi-cycle in EX.
REQ-013 i_interrupt  in  1  interrupt/exception flush request.
REQ-014 o_stall  out  1  hold PC and IF/ID, inject bubble into EX.
REQ-015 o_flush  out  1  squash IF/ID and ID/EX contents.
REQ-016 o_fwd_sel  out  NUM_SRC*2  per-source bypass: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-017 o_busy  out  1  multi-cycle op occupying EX.

Function
REQ-018 Block SHALL track EX, MEM, WB entries {valid, dst, load}; each cycle ID->EX->MEM->WB->retire unless stalled or flushed.
REQ-019 An ID instruction SHALL enter EX valid only if i_id_valid=1, i_id_regwr=1, o_stall=0, o_flush=0; otherwise EX receives a bubble (valid=0).
REQ-020 Source k matches stage S when used, address nonzero, S valid, S.dst equal; address 0 SHALL never match.
REQ-021 o_fwd_sel per source SHALL select youngest match, priority EX > MEM > WB; no match -> 00; outputs combinational from tracked state and current ID inputs.
REQ-022 Load-use: source match on EX entry with load=1 SHALL assert o_stall for exactly one cycle; next cycle the load sits in MEM and selector is 10.
REQ-023 State machine RUN/MULTI/FLUSH; RUN->MULTI when an instruction with i_id_multi=1 enters EX; cycle counter loads MUL_CYC-1.
REQ-024 In MULTI: o_busy=1, o_stall=1, EX entry held, MEM receives bubble, counter decrements; at counter 0 SHALL return to RUN and EX advances next edge.
REQ-025 i_interrupt=1 (any state) SHALL: o_flush=1 same cycle, clear EX entry, abort counter, go to FLUSH; MEM and WB entries continue.
REQ-026 FLUSH lasts one cycle: o_flush=1, i_id_valid ignored, o_stall=0; then RUN; i_interrupt in FLUSH re-enters FLUSH.
REQ-027 o_flush=1 SHALL force o_stall=0 (flush dominates stall).
REQ-028 o_stall=0 whenever i_id_valid=0 and state is RUN.

Reset
REQ-029 While i_rst_n=0 at an edge: all stage valids 0, counter 0, state RUN; consequently o_stall=0, o_flush=0, o_busy=0, o_fwd_sel all 00 (given i_interrupt=0).
REQ-030 Reset mid-MULTI or mid-FLUSH SHALL abandon the operation with no residual stall.

Configuration
REQ-031 Macro PIPELINE_HAZARD_WB_BYPASS_EN defined: WB matches produce selector 11.
REQ-032 Macro undefined: selector 11 never produced; a WB-only match SHALL assert o_stall one cycle, after which the entry retires and selector is 00.

Structure
REQ-033 Shared package pipeline_pkg SHALL hold fwd selector encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), state encodings, RA_W default.
REQ-034 Per-source comparison SHALL be sub-module pipeline_fwd_match, instantiated NUM_SRC times via generate.

Verification
REQ-035 Add r3 in EX, next ID reads r3 on src0 -> o_fwd_sel[1:0]=01, o_stall=0.
REQ-036 Load r5 in EX, ID reads r5 on src1 -> o_stall=1 one cycle, then o_fwd_sel[3:2]=10.
REQ-037 Multi op enters EX, MUL_CYC=4 -> o_busy=1 and o_stall=1 for 3 cycles, MEM bubbles, then RUN.
REQ-038 i_interrupt during cycle 2 of MULTI -> o_flush=1 two cycles, o_busy=0 next cycle, EX valid cleared.
REQ-039 ID reads r0 with r0 in EX/MEM/WB -> selector 00, no stall.
REQ-040 r7 only in WB, ID reads r7 -> selector 11 with macro; without macro o_stall=1 one cycle then 00.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               forwarding selector encodings, controller state encoding and
//               the default register-address width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int RA_W_DEFAULT = 5;

    // Operand bypass selector, one 2-bit field per source operand.
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_EX  = 2'b01;  // EX-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;  // MEM-stage result
    localparam logic [1:0] FWD_WB  = 2'b11;  // WB-stage result

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_MULTI = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_fwd_match
// Description : Compares one ID source operand against the EX/MEM/WB
//               destinations and picks the youngest producer.
// Revision    : 1.0 - initial release
// Config      : PIPELINE_HAZARD_WB_BYPASS_EN - when defined a WB producer is
//               bypassed (FWD_WB); otherwise it requests a one-cycle stall.
// Ports       : i_src/i_src_used      - source address and read flag
//               i_{ex,mem,wb}_valid/dst - tracked stage entries
//               i_ex_load              - EX entry is a load
//               o_sel                  - bypass selector for this source
//               o_load_use             - youngest producer is a load in EX
//               o_wb_stall             - WB-only producer, no WB bypass path
// ============================================================================
module pipeline_fwd_match
    import pipeline_pkg::*;
#(
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic [RA_W-1:0] i_src,
    input  logic            i_src_used,
    input  logic            i_ex_valid,
    input  logic [RA_W-1:0] i_ex_dst,
    input  logic            i_ex_load,
    input  logic            i_mem_valid,
    input  logic [RA_W-1:0] i_mem_dst,
    input  logic            i_wb_valid,
    input  logic [RA_W-1:0] i_wb_dst,
    output logic [1:0]      o_sel,
    output logic            o_load_use,
    output logic            o_wb_stall
);

    logic w_active;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    // r0 is hard-wired zero, so it never has a producer to bypass from.
    assign w_active  = i_src_used && (i_src != '0);
    assign w_hit_ex  = w_active && i_ex_valid  && (i_ex_dst  == i_src);
    assign w_hit_mem = w_active && i_mem_valid && (i_mem_dst == i_src);
    assign w_hit_wb  = w_active && i_wb_valid  && (i_wb_dst  == i_src);

    assign o_load_use = w_hit_ex && i_ex_load;

    always_comb begin
        o_sel      = FWD_RF;
        o_wb_stall = 1'b0;
        if (w_hit_ex) begin
            o_sel = FWD_EX;
        end else if (w_hit_mem) begin
            o_sel = FWD_MEM;
        end else if (w_hit_wb) begin
`ifdef PIPELINE_HAZARD_WB_BYPASS_EN
            o_sel = FWD_WB;
`else
            // No WB bypass path: wait one cycle for the write to land.
            o_wb_stall = 1'b1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard controller for an in-order pipeline. Tracks the
//               EX/MEM/WB destination registers, produces per-operand bypass
//               selects, load-use / multi-cycle stalls and interrupt flushes.
// Revision    : 1.0 - initial release
// Config      : PIPELINE_HAZARD_WB_BYPASS_EN - enables bypass from WB (11).
// Ports       : i_clk, i_rst_n (sync, active-low)
//               i_id_*       - decoded instruction in ID
//               i_interrupt  - flush request
//               o_stall      - hold PC and IF/ID, bubble into EX
//               o_flush      - squash IF/ID and ID/EX
//               o_fwd_sel    - 2-bit bypass select per source operand
//               o_busy       - multi-cycle op occupying EX
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int RA_W    = RA_W_DEFAULT,
    parameter int NUM_SRC = 2,
    parameter int MUL_CYC = 4               // legal range 2..16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_id_valid,
    input  logic [NUM_SRC*RA_W-1:0] i_id_src,
    input  logic [NUM_SRC-1:0]      i_id_src_used,
    input  logic [RA_W-1:0]         i_id_dst,
    input  logic                    i_id_regwr,
    input  logic                    i_id_load,
    input  logic                    i_id_multi,
    input  logic                    i_interrupt,
    output logic                    o_stall,
    output logic                    o_flush,
    output logic [NUM_SRC*2-1:0]    o_fwd_sel,
    output logic                    o_busy
);

    localparam int             CNT_W    = $clog2(MUL_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYC - 1);

    hz_state_e        r_state;
    hz_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt;

    // Load flag is only consulted in EX (load-use); data is ready after MEM,
    // so later stages need only valid and destination.
    logic             r_ex_valid;
    logic [RA_W-1:0]  r_ex_dst;
    logic             r_ex_load;
    logic             r_mem_valid;
    logic [RA_W-1:0]  r_mem_dst;
    logic             r_wb_valid;
    logic [RA_W-1:0]  r_wb_dst;

    logic [NUM_SRC-1:0] w_load_use;
    logic [NUM_SRC-1:0] w_wb_stall;
    logic               w_hazard;
    logic               w_id_accept;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        pipeline_fwd_match #(
            .RA_W (RA_W)
        ) u_match (
            .i_src       (i_id_src[k*RA_W +: RA_W]),
            .i_src_used  (i_id_src_used[k]),
            .i_ex_valid  (r_ex_valid),
            .i_ex_dst    (r_ex_dst),
            .i_ex_load   (r_ex_load),
            .i_mem_valid (r_mem_valid),
            .i_mem_dst   (r_mem_dst),
            .i_wb_valid  (r_wb_valid),
            .i_wb_dst    (r_wb_dst),
            .o_sel       (o_fwd_sel[k*2 +: 2]),
            .o_load_use  (w_load_use[k]),
            .o_wb_stall  (w_wb_stall[k])
        );
    end

    assign w_hazard = i_id_valid && ((|w_load_use) || (|w_wb_stall));

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_stall      = 1'b0;
        o_flush      = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_stall = w_hazard;
                if (i_id_valid && i_id_multi && !w_hazard) begin
                    w_state_next = ST_MULTI;
                end
            end
            ST_MULTI: begin
                o_busy  = 1'b1;
                o_stall = 1'b1;
                // Counter reaches zero on this edge; EX is released next.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                o_flush      = 1'b1;
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
        // Interrupt overrides everything; a flush never stalls.
        if (i_interrupt) begin
            o_flush      = 1'b1;
            o_stall      = 1'b0;
            w_state_next = ST_FLUSH;
        end
    end

    assign w_id_accept = (r_state == ST_RUN) && i_id_valid && !o_stall && !o_flush;

    // ------------------------------------------------------------------
    // Stage tracking and multi-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_dst    <= '0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_dst   <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_dst    <= '0;
            r_cnt       <= '0;
        end else if (i_interrupt) begin
            // The EX instruction is squashed rather than advanced; older
            // instructions in MEM/WB still complete.
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= r_mem_valid;
            r_wb_dst    <= r_mem_dst;
            r_cnt       <= '0;
        end else if (r_state == ST_MULTI) begin
            // EX holds the multi-cycle op; bubbles flow out behind it.
            r_mem_valid <= 1'b0;
            r_wb_valid  <= r_mem_valid;
            r_wb_dst    <= r_mem_dst;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else begin
            r_ex_valid  <= w_id_accept && i_id_regwr;
            r_ex_dst    <= i_id_dst;
            r_ex_load   <= i_id_load;
            r_mem_valid <= r_ex_valid;
            r_mem_dst   <= r_ex_dst;
            r_wb_valid  <= r_mem_valid;
            r_wb_dst    <= r_mem_dst;
            if (w_id_accept && i_id_multi) begin
                r_cnt <= CNT_LOAD;
            end
        end
    end

endmodule
`default_nettype wire
